overlay_sprite_display: RTL and testbench

//  Parametrised full-screen-message overlay (game-over, pause, level banners) for the VGA pixel path.

---
 rtl/overlay_sprite_display_pkg.sv | 26 ++
 rtl/overlay_sprite_display_if.sv | 37 +++
 rtl/overlay_sprite_display_window.sv | 67 ++++++
 rtl/overlay_sprite_display.sv | 163 ++++++++++++++++
 tb/tb_overlay_sprite_display.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/overlay_sprite_display_pkg.sv
// ============================================================================
// Module      : overlay_sprite_display_pkg
// Description : Shared display constants, FSM state encodings and the default
//               transparent colour used by the sprite overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package overlay_sprite_display_pkg;

    localparam int c_screen_w = 640;
    localparam int c_screen_h = 480;
    localparam int c_coord_w  = 10;
    localparam int c_color_w  = 12;

    localparam logic [c_color_w-1:0] c_key_color_default = 12'h6DE;

    typedef logic [1:0] ovl_state_t;

    localparam ovl_state_t c_st_idle  = 2'd0;
    localparam ovl_state_t c_st_blink = 2'd1;
    localparam ovl_state_t c_st_show  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/overlay_sprite_display_if.sv
// ============================================================================
// Module      : overlay_if
// Description : Pixel-path bundle between pixel counters, image ROM and the
//               sprite overlay (slave = overlay, master = surrounding logic).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface overlay_if #(
    parameter int ADDR_W = 11
) ();
    import overlay_sprite_display_pkg::*;

    logic [c_coord_w-1:0] x;
    logic [c_coord_w-1:0] y;
    logic                 frame_tick;
    logic                 show;
    logic                 clear;
    logic [ADDR_W-1:0]    rom_addr;
    logic [c_color_w-1:0] rom_data;
    logic [c_color_w-1:0] rgb_out;
    logic                 overlay_on;
    logic                 active;

    modport master (
        output x, y, frame_tick, show, clear, rom_data,
        input  rom_addr, rgb_out, overlay_on, active
    );

    modport slave (
        input  x, y, frame_tick, show, clear, rom_data,
        output rom_addr, rgb_out, overlay_on, active
    );

endinterface

`default_nettype wire

// File: rtl/overlay_sprite_display_window.sv
// ============================================================================
// Module      : overlay_window
// Description : Image window compare, {row,col} ROM address generation and the
//               ROM_LAT-deep delay line that aligns win/vis with ROM data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module overlay_window
    import overlay_sprite_display_pkg::*;
#(
    parameter int X0      = 282,
    parameter int Y0      = 72,
    parameter int W       = 78,
    parameter int H       = 14,
    parameter int COL_W   = 7,
    parameter int ROW_W   = 4,
    parameter int ROM_LAT = 1
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic [c_coord_w-1:0]   i_x,
    input  wire logic [c_coord_w-1:0]   i_y,
    input  wire logic                   i_vis,
    output logic      [ROW_W+COL_W-1:0] o_rom_addr,
    output logic                        o_win_d,
    output logic                        o_vis_d
);

    localparam logic [c_coord_w-1:0] c_x0   = c_coord_w'(X0);
    localparam logic [c_coord_w-1:0] c_y0   = c_coord_w'(Y0);
    // One extra bit so X0+W / Y0+H at the screen edge cannot wrap.
    localparam logic [c_coord_w:0]   c_x_lo = (c_coord_w+1)'(X0);
    localparam logic [c_coord_w:0]   c_x_hi = (c_coord_w+1)'(X0 + W);
    localparam logic [c_coord_w:0]   c_y_lo = (c_coord_w+1)'(Y0);
    localparam logic [c_coord_w:0]   c_y_hi = (c_coord_w+1)'(Y0 + H);

    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic               w_win;
    logic [ROM_LAT-1:0] r_win_sr;
    logic [ROM_LAT-1:0] r_vis_sr;

    assign w_col = COL_W'(i_x - c_x0);
    assign w_row = ROW_W'(i_y - c_y0);

    assign o_rom_addr = reset ? '0 : {w_row, w_col};

    assign w_win = ({1'b0, i_x} >= c_x_lo) && ({1'b0, i_x} < c_x_hi) &&
                   ({1'b0, i_y} >= c_y_lo) && ({1'b0, i_y} < c_y_hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_sr <= '0;
            r_vis_sr <= '0;
        end else begin
            r_win_sr <= ROM_LAT'({r_win_sr, w_win});
            r_vis_sr <= ROM_LAT'({r_vis_sr, i_vis});
        end
    end

    assign o_win_d = r_win_sr[ROM_LAT-1];
    assign o_vis_d = r_vis_sr[ROM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/overlay_sprite_display.sv
// ============================================================================
// Module      : overlay_sprite_display
// Description : Full-screen message overlay with colour keying and a
//               frame-synchronous show/blink/clear FSM.
//               Optional blink phase enabled by defining OVERLAY_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module overlay_sprite_display
    import overlay_sprite_display_pkg::*;
#(
    parameter int                   X0            = 282,
    parameter int                   Y0            = 72,
    parameter int                   W             = 78,
    parameter int                   H             = 14,
    parameter int                   COL_W         = 7,
    parameter int                   ROW_W         = 4,
    parameter logic [c_color_w-1:0] KEY_COLOR     = c_key_color_default,
    parameter int                   ROM_LAT       = 1,
    parameter int                   BLINK_FRAMES  = 16,
    parameter int                   BLINK_TOGGLES = 6
) (
    input  wire logic clk,
    input  wire logic reset,
    overlay_if.slave  bus
);

    ovl_state_t r_state;
    ovl_state_t w_state_nxt;
    logic       r_vis;
    logic       w_vis_nxt;
    logic       r_pend_show;
    logic       r_pend_clr;
    logic       w_vis;
    logic       w_active;
    logic       w_win_d;
    logic       w_vis_d;
    logic       w_on;

`ifdef OVERLAY_BLINK_EN
    localparam int c_fc_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_tc_w = $clog2(BLINK_TOGGLES + 1);
    localparam logic [c_fc_w-1:0] c_fc_last = c_fc_w'(BLINK_FRAMES - 1);
    localparam logic [c_fc_w-1:0] c_fc_one  = c_fc_w'(1);
    localparam logic [c_tc_w-1:0] c_tc_last = c_tc_w'(BLINK_TOGGLES - 1);
    localparam logic [c_tc_w-1:0] c_tc_one  = c_tc_w'(1);

    logic [c_fc_w-1:0] r_frame_cnt;
    logic [c_fc_w-1:0] w_frame_cnt_nxt;
    logic [c_tc_w-1:0] r_toggle_cnt;
    logic [c_tc_w-1:0] w_toggle_cnt_nxt;
`endif

    // Requests are held until the next frame_tick; one arriving on the tick
    // itself is kept for the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_vis        <= 1'b0;
            r_pend_show  <= 1'b0;
            r_pend_clr   <= 1'b0;
`ifdef OVERLAY_BLINK_EN
            r_frame_cnt  <= '0;
            r_toggle_cnt <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_vis        <= w_vis_nxt;
            r_pend_show  <= (r_pend_show & ~bus.frame_tick) | bus.show;
            r_pend_clr   <= (r_pend_clr  & ~bus.frame_tick) | bus.clear;
`ifdef OVERLAY_BLINK_EN
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_toggle_cnt <= w_toggle_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_vis_nxt        = r_vis;
`ifdef OVERLAY_BLINK_EN
        w_frame_cnt_nxt  = r_frame_cnt;
        w_toggle_cnt_nxt = r_toggle_cnt;
`endif
        if (bus.frame_tick) begin
            case (r_state)
                c_st_idle: begin
                    if (!r_pend_clr && r_pend_show) begin
`ifdef OVERLAY_BLINK_EN
                        w_state_nxt      = c_st_blink;
                        w_frame_cnt_nxt  = '0;
                        w_toggle_cnt_nxt = '0;
`else
                        w_state_nxt      = c_st_show;
`endif
                        w_vis_nxt        = 1'b1;
                    end
                end
`ifdef OVERLAY_BLINK_EN
                c_st_blink: begin
                    if (r_pend_clr) begin
                        w_state_nxt = c_st_idle;
                        w_vis_nxt   = 1'b0;
                    end else if (r_frame_cnt == c_fc_last) begin
                        w_frame_cnt_nxt  = '0;
                        w_vis_nxt        = ~r_vis;
                        w_toggle_cnt_nxt = r_toggle_cnt + c_tc_one;
                        if (r_toggle_cnt == c_tc_last) begin
                            w_state_nxt = c_st_show;
                            w_vis_nxt   = 1'b1;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_fc_one;
                    end
                end
`endif
                c_st_show: begin
                    if (r_pend_clr) begin
                        w_state_nxt = c_st_idle;
                        w_vis_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_vis_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_active = (r_state != c_st_idle);
        w_vis    = r_vis;
    end

    overlay_window #(
        .X0      (X0),
        .Y0      (Y0),
        .W       (W),
        .H       (H),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W),
        .ROM_LAT (ROM_LAT)
    ) u_window (
        .clk        (clk),
        .reset      (reset),
        .i_x        (bus.x),
        .i_y        (bus.y),
        .i_vis      (w_vis),
        .o_rom_addr (bus.rom_addr),
        .o_win_d    (w_win_d),
        .o_vis_d    (w_vis_d)
    );

    assign w_on           = w_win_d & w_vis_d & (bus.rom_data != KEY_COLOR);
    assign bus.overlay_on = w_on;
    assign bus.rgb_out    = w_on ? bus.rom_data : '0;
    assign bus.active     = w_active;

endmodule

`default_nettype wire

// File: tb/tb_overlay_sprite_display.sv
// ============================================================================
// Module      : tb_overlay_sprite_display
// Description : Self-checking bench for overlay_sprite_display with a
//               behavioural ROM and a frame-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_overlay_sprite_display;
    import overlay_sprite_display_pkg::*;

    localparam int          X0    = 282;
    localparam int          Y0    = 72;
    localparam int          W     = 78;
    localparam int          H     = 14;
    localparam int          COL_W = 7;
    localparam int          ROW_W = 4;
    localparam int          BF    = 2;
    localparam int          BT    = 6;
    localparam logic [11:0] KEY   = 12'h6DE;
`ifdef OVERLAY_BLINK_EN
    localparam bit c_blink = 1'b1;
`else
    localparam bit c_blink = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    overlay_if #(.ADDR_W(ROW_W + COL_W)) bus ();

    overlay_sprite_display #(
        .X0            (X0),
        .Y0            (Y0),
        .W             (W),
        .H             (H),
        .COL_W         (COL_W),
        .ROW_W         (ROW_W),
        .KEY_COLOR     (KEY),
        .ROM_LAT       (1),
        .BLINK_FRAMES  (BF),
        .BLINK_TOGGLES (BT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] rom_mem [0:(1 << (ROW_W + COL_W)) - 1];

    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    // Reference model: is the overlay running, and how many frame ticks since it started.
    bit m_run;
    int m_frames;
    bit m_ps;
    bit m_pc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run    <= 1'b0;
            m_frames <= 0;
            m_ps     <= 1'b0;
            m_pc     <= 1'b0;
        end else if (bus.frame_tick) begin
            if (m_pc) begin
                m_run <= 1'b0;
            end else if (m_run) begin
                m_frames <= m_frames + 1;
            end else if (m_ps) begin
                m_run    <= 1'b1;
                m_frames <= 0;
            end
            m_ps <= bus.show;
            m_pc <= bus.clear;
        end else begin
            m_ps <= m_ps | bus.show;
            m_pc <= m_pc | bus.clear;
        end
    end

    function automatic bit model_vis();
        if (!m_run) return 1'b0;
        if (!c_blink || m_frames >= BF * BT) return 1'b1;
        return ((m_frames / BF) % 2) == 0;
    endfunction

    function automatic bit in_win(input int px, input int py);
        return (px >= X0) && (px < X0 + W) && (py >= Y0) && (py < Y0 + H);
    endfunction

    function automatic int exp_addr(input int px, input int py);
        int r;
        int c;
        r = (((py - Y0) % (1 << ROW_W)) + (1 << ROW_W)) % (1 << ROW_W);
        c = (((px - X0) % (1 << COL_W)) + (1 << COL_W)) % (1 << COL_W);
        return r * (1 << COL_W) + c;
    endfunction

    bit last_win;
    bit last_vis;
    int last_addr;

    function automatic bit exp_on();
        return last_win && last_vis && (rom_mem[last_addr] != KEY);
    endfunction

    function automatic logic [11:0] exp_rgb();
        return exp_on() ? rom_mem[last_addr] : 12'h000;
    endfunction

    task automatic step(input int px, input int py, input bit ft, input bit sh, input bit cl);
        bus.x          = 10'(px);
        bus.y          = 10'(py);
        bus.frame_tick = ft;
        bus.show       = sh;
        bus.clear      = cl;
        last_win       = in_win(px, py);
        last_vis       = model_vis();
        last_addr      = exp_addr(px, py);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL rst_on: got %b want 0", bus.overlay_on); else pass_cnt++;
        chk_cnt++; if (bus.rgb_out !== 12'h000) $display("FAIL rst_rgb: got %h want 000", bus.rgb_out); else pass_cnt++;
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL rst_active: got %b want 0", bus.active); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== 11'd0) $display("FAIL rst_addr: got %0d want 0", bus.rom_addr); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        // Reach the steady shown state, then put an opaque pixel on screen.
        step(0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i <= BF * BT; i++) step(0, 0, 1'b1, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        rom_mem[exp_addr(282, 72)] = 12'hF00;
        step(282, 72, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.overlay_on !== 1'b1) $display("FAIL pre_rst_on: got %b want 1", bus.overlay_on); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL mid_rst_on: got %b want 0", bus.overlay_on); else pass_cnt++;
        chk_cnt++; if (bus.rgb_out !== 12'h000) $display("FAIL mid_rst_rgb: got %h want 000", bus.rgb_out); else pass_cnt++;
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL mid_rst_active: got %b want 0", bus.active); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        step(282, 72, 1'b1, 1'b0, 1'b0);
        step(282, 72, 1'b1, 1'b0, 1'b0);
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL post_rst_active: got %b want 0", bus.active); else pass_cnt++;
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL post_rst_on: got %b want 0", bus.overlay_on); else pass_cnt++;
    endtask

    task automatic test_show_pixel();
        do_reset();
        step(0, 0, 1'b0, 1'b1, 1'b0);
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL show_wait: got %b want 0", bus.active); else pass_cnt++;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        chk_cnt++; if (bus.active !== 1'b1) $display("FAIL show_active: got %b want 1", bus.active); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== 11'(exp_addr(0, 0))) $display("FAIL addr_wrap: got %0d want %0d", bus.rom_addr, exp_addr(0, 0)); else pass_cnt++;
        rom_mem[exp_addr(282, 72)] = 12'hF00;
        step(282, 72, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.rom_addr !== 11'd0) $display("FAIL addr_origin: got %0d want 0", bus.rom_addr); else pass_cnt++;
        chk_cnt++; if (bus.overlay_on !== 1'b1) $display("FAIL origin_on: got %b want 1", bus.overlay_on); else pass_cnt++;
        chk_cnt++; if (bus.rgb_out !== 12'hF00) $display("FAIL origin_rgb: got %h want F00", bus.rgb_out); else pass_cnt++;
        rom_mem[exp_addr(360, 72)] = 12'h0F0;
        step(360, 72, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL right_edge_on: got %b want 0", bus.overlay_on); else pass_cnt++;
        rom_mem[exp_addr(282, 86)] = 12'h0F0;
        step(282, 86, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL bottom_edge_on: got %b want 0", bus.overlay_on); else pass_cnt++;
        rom_mem[exp_addr(281, 72)] = 12'h0F0;
        step(281, 72, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL left_edge_on: got %b want 0", bus.overlay_on); else pass_cnt++;
        rom_mem[exp_addr(359, 85)] = 12'h00F;
        step(359, 85, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.rgb_out !== 12'h00F) $display("FAIL last_pixel_rgb: got %h want 00F", bus.rgb_out); else pass_cnt++;
    endtask

    task automatic test_key_color();
        rom_mem[exp_addr(300, 80)] = KEY;
        step(300, 80, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.overlay_on !== 1'b0) $display("FAIL key_on: got %b want 0", bus.overlay_on); else pass_cnt++;
        chk_cnt++; if (bus.rgb_out !== 12'h000) $display("FAIL key_rgb: got %h want 000", bus.rgb_out); else pass_cnt++;
        rom_mem[exp_addr(301, 80)] = KEY + 12'h001;
        step(301, 80, 1'b0, 1'b0, 1'b0);
        chk_cnt++; if (bus.rgb_out !== 12'h6DF) $display("FAIL near_key_rgb: got %h want 6DF", bus.rgb_out); else pass_cnt++;
    endtask

    task automatic test_vis_sequence();
        bit want;
        do_reset();
        rom_mem[exp_addr(320, 78)] = 12'h123;
        step(0, 0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0, 1'b0);
        for (int f = 0; f < BF * BT + 4; f++) begin
            want = (!c_blink || f >= BF * BT) ? 1'b1 : (((f / BF) % 2) == 0);
            step(320, 78, 1'b0, 1'b0, 1'b0);
            chk_cnt++; if (bus.overlay_on !== want) $display("FAIL vis_frame%0d: got %b want %b", f, bus.overlay_on, want); else pass_cnt++;
            chk_cnt++; if (bus.active !== 1'b1) $display("FAIL vis_active%0d: got %b want 1", f, bus.active); else pass_cnt++;
            step(0, 0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_show_clear();
        do_reset();
        step(0, 0, 1'b0, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b0, 1'b0);
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL both_tick1: got %b want 0", bus.active); else pass_cnt++;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL both_tick2: got %b want 0", bus.active); else pass_cnt++;
        step(0, 0, 1'b1, 1'b1, 1'b0);
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL coinc_tick: got %b want 0", bus.active); else pass_cnt++;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        chk_cnt++; if (bus.active !== 1'b1) $display("FAIL coinc_next: got %b want 1", bus.active); else pass_cnt++;
        step(0, 0, 1'b0, 1'b0, 1'b1);
        chk_cnt++; if (bus.active !== 1'b1) $display("FAIL clr_hold: got %b want 1", bus.active); else pass_cnt++;
        step(0, 0, 1'b1, 1'b0, 1'b0);
        chk_cnt++; if (bus.active !== 1'b0) $display("FAIL clr_tick: got %b want 0", bus.active); else pass_cnt++;
    endtask

    task automatic test_random();
        int px;
        int py;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            px = $urandom_range(X0 - 12, X0 + W + 12);
            py = $urandom_range(Y0 - 6, Y0 + H + 6);
            step(px, py, ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 79) == 0));
            chk_cnt++; if (bus.overlay_on !== exp_on()) $display("FAIL rnd_on%0d: got %b want %b", n, bus.overlay_on, exp_on()); else pass_cnt++;
            chk_cnt++; if (bus.rgb_out !== exp_rgb()) $display("FAIL rnd_rgb%0d: got %h want %h", n, bus.rgb_out, exp_rgb()); else pass_cnt++;
            chk_cnt++; if (bus.active !== m_run) $display("FAIL rnd_active%0d: got %b want %b", n, bus.active, m_run); else pass_cnt++;
        end
    endtask

    initial begin
        bus.x          = '0;
        bus.y          = '0;
        bus.frame_tick = 1'b0;
        bus.show       = 1'b0;
        bus.clear      = 1'b0;
        for (int i = 0; i < (1 << (ROW_W + COL_W)); i++) begin
            rom_mem[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
        end
        @(negedge clk);
        test_reset();
        test_show_pixel();
        test_key_color();
        test_vis_sequence();
        test_show_clear();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
